// File: rtl/axi_fifo_responder.sv
// axi_fifo_responder: responder end of the simple AXI-style write/read link.
// Write beats {addr,data} are queued in a DEPTH-entry FIFO and popped in order
// on read requests; read_data is registered at the accepting edge.
// Ports: clk, rst (sync, active-high); write_addr/write_data/write_valid ->
// write_ready; read_addr/read_valid -> read_ready, read_data;
// fifo_full, fifo_empty status.
// Optional: define AXI_FIFO_ADDR_CHECK_EN to compare read_addr against the
// head address and return ERR_DATA on mismatch (the entry is still popped).
module axi_fifo_responder #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        write_valid,
  output logic        write_ready,
  input  logic [31:0] read_addr,
  input  logic        read_valid,
  output logic        read_ready,
  output logic [31:0] read_data,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_read_data;

  logic          w_wr;
  logic          w_rd;
  logic [31:0]   w_rd_val;

  // Status and readies come from the registered count only, so a read
  // freeing a full slot cannot admit a write on the same edge.
  assign fifo_full   = (r_count == FULL_CNT);
  assign fifo_empty  = (r_count == '0);
  assign write_ready = !fifo_full && !rst;
  assign read_ready  = !fifo_empty && !rst;
  assign read_data   = r_read_data;

  assign w_wr = write_valid && write_ready;
  assign w_rd = read_valid && read_ready;

`ifdef AXI_FIFO_ADDR_CHECK_EN
  logic [31:0] r_mem_addr [DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem_addr[r_wptr] <= write_addr;
  end

  always_comb begin
    w_rd_val = r_mem_data[r_rptr];
    if (read_addr != r_mem_addr[r_rptr])
      w_rd_val = ERR_DATA;
  end
`else
  logic w_unused;
  assign w_unused = ^{read_addr, write_addr, ERR_DATA};

  always_comb begin
    w_rd_val = r_mem_data[r_rptr];
  end
`endif

  always_ff @(posedge clk) begin
    if (w_wr) r_mem_data[r_wptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_read_data <= 32'h0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr      <= r_rptr + 1'b1;
        r_read_data <= w_rd_val;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
